// File: rtl/window_generator_w3x3.sv
// rtl/window_generator_w3x3.sv - raster pixel stream to sliding 3x3 interior window
// Two line buffers hold the previous rows; a 3x3 register array shifts one column per pixel.
module window_generator_w3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iValid,
  input  logic              iSof,
  input  logic [DATA_W-1:0] iPixel,
  output logic              oValid,
  output logic [DATA_W-1:0] oP11,
  output logic [DATA_W-1:0] oP12,
  output logic [DATA_W-1:0] oP13,
  output logic [DATA_W-1:0] oP21,
  output logic [DATA_W-1:0] oP22,
  output logic [DATA_W-1:0] oP23,
  output logic [DATA_W-1:0] oP31,
  output logic [DATA_W-1:0] oP32,
  output logic [DATA_W-1:0] oP33,
  output logic              oFrameDone
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]     col_q, col_d, pos_col;
  logic [RW-1:0]     row_q, row_d, pos_row;
  logic              active_q, active_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              accept;
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_d [3][3];
  logic [DATA_W-1:0] lb0_q [IMG_WIDTH];
  logic [DATA_W-1:0] lb1_q [IMG_WIDTH];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  // Pixels are ignored until an SOF has been seen since reset.
  assign accept  = iValid && (iSof || active_q);
  assign pos_col = iSof ? '0 : col_q;
  assign pos_row = iSof ? '0 : row_q;
  assign lb0_rd  = lb0_q[pos_col];
  assign lb1_rd  = lb1_q[pos_col];

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    active_d = active_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    win_d    = win_q;
    if (accept) begin
      active_d = 1'b1;
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = iPixel;
      // col>=2 keeps all three window columns inside one line.
      valid_d = (pos_row >= RW'(2)) && (pos_col >= CW'(2));
      done_d  = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      win_q    <= win_d;
    end
  end

  // Line buffers are not reset; row>=2 gating masks stale contents.
  always_ff @(posedge iClk) begin
    if (accept) begin
      lb1_q[pos_col] <= lb0_rd;
      lb0_q[pos_col] <= iPixel;
    end
  end

  assign oValid     = valid_q;
  assign oFrameDone = done_q;
  assign oP11 = win_q[0][0];
  assign oP12 = win_q[0][1];
  assign oP13 = win_q[0][2];
  assign oP21 = win_q[1][0];
  assign oP22 = win_q[1][1];
  assign oP23 = win_q[1][2];
  assign oP31 = win_q[2][0];
  assign oP32 = win_q[2][1];
  assign oP33 = win_q[2][2];

endmodule

// File: tb/tb_window_generator_w3x3.sv
// tb/tb_window_generator_w3x3.sv - scoreboard bench for window_generator_w3x3
module tb_window_generator_w3x3;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          iValid = 1'b0;
  logic          iSof = 1'b0;
  logic [DW-1:0] iPixel = '0;
  logic          oValid, oFrameDone;
  logic [DW-1:0] oP11, oP12, oP13, oP21, oP22, oP23, oP31, oP32, oP33;

  window_generator_w3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
    .iClk(clk), .iRst_n(rst_n), .iValid(iValid), .iSof(iSof), .iPixel(iPixel),
    .oValid(oValid),
    .oP11(oP11), .oP12(oP12), .oP13(oP13),
    .oP21(oP21), .oP22(oP22), .oP23(oP23),
    .oP31(oP31), .oP32(oP32), .oP33(oP33),
    .oFrameDone(oFrameDone)
  );

  always #5 clk = ~clk;

  typedef logic [9*DW-1:0] win_t;

  win_t     exp_q[$];
  int       done_exp = 0;
  int       checks = 0;
  int       errs = 0;
  int       seg_count = 0;
  int       seg_done = 0;
  win_t     seg_first, seg_last;
  logic     prev_valid = 1'b0;
  win_t     prev_out = '0;

  // Reference model: the current frame as a flat raster array.
  bit       m_active = 0;
  int       m_k = 0;
  logic [DW-1:0] m_frame [W*H];

  function automatic win_t got_win();
    return {oP11, oP12, oP13, oP21, oP22, oP23, oP31, oP32, oP33};
  endfunction

  task automatic model_accept(input logic [DW-1:0] px, input bit sof);
    int r, c;
    win_t w;
    if (sof) begin
      m_active = 1;
      m_k = 0;
    end
    if (!m_active) return;
    m_frame[m_k] = px;
    r = m_k / W;
    c = m_k % W;
    if (r >= 2 && c >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w[(8 - (i*3 + j))*DW +: DW] = m_frame[(r-2+i)*W + (c-2+j)];
      exp_q.push_back(w);
    end
    if (m_k == W*H-1) begin
      done_exp++;
      m_k = 0;
    end else begin
      m_k++;
    end
  endtask

  task automatic drive(input logic [DW-1:0] px, input bit sof, input int stalls);
    repeat (stalls) begin
      iValid = 1'b0;
      iSof = 1'b0;
      @(posedge clk); #1;
    end
    iValid = 1'b1;
    iSof = sof;
    iPixel = px;
    model_accept(px, sof);
    @(posedge clk); #1;
    iValid = 1'b0;
    iSof = 1'b0;
  endtask

  task automatic send_frame(input int base, input int stall_mode);
    for (int i = 0; i < W*H; i++)
      drive(DW'(base + i), i == 0, (stall_mode == 1) ? 1 : 0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || done_exp != 0) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || done_exp != 0) begin
      errs++;
      $display("FAIL %s drain: pending windows=%0d frame_done=%0d, required 0/0", name, exp_q.size(), done_exp);
      exp_q.delete();
      done_exp = 0;
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errs++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic check_win(input string name, input win_t got, input win_t req);
    checks++;
    if (got !== req) begin
      errs++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  always @(posedge clk) prev_valid <= iValid;

  // Monitor: pops expected windows whenever the DUT presents one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (oValid) begin
        checks++;
        if (!prev_valid) begin
          errs++;
          $display("FAIL stall_valid: oValid=1 after a cycle with iValid=0, required 0");
        end else if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_window: got %h, required no window", got_win());
        end else begin
          win_t w;
          w = exp_q.pop_front();
          if (got_win() !== w) begin
            errs++;
            $display("FAIL window: got %h, required %h", got_win(), w);
          end
        end
        if (seg_count == 0) seg_first = got_win();
        seg_last = got_win();
        seg_count++;
      end else if (!prev_valid) begin
        checks++;
        if (got_win() !== prev_out) begin
          errs++;
          $display("FAIL hold: got %h, required %h", got_win(), prev_out);
        end
      end
      if (oFrameDone) begin
        checks++;
        seg_done++;
        if (done_exp == 0) begin
          errs++;
          $display("FAIL frame_done: got unexpected pulse, required 0");
        end else begin
          done_exp--;
        end
      end
    end
    prev_out = got_win();
  end

  function automatic win_t mkwin(input int a0, input int a1, input int a2,
                                 input int b0, input int b1, input int b2,
                                 input int c0, input int c1, input int c2);
    return {DW'(a0), DW'(a1), DW'(a2), DW'(b0), DW'(b1), DW'(b2), DW'(c0), DW'(c1), DW'(c2)};
  endfunction

  task automatic seg_reset();
    seg_count = 0;
    seg_done = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_int("reset_valid", int'(oValid), 0);
    check_int("reset_done", int'(oFrameDone), 0);
    check_win("reset_window", got_win(), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: continuous frame
    seg_reset();
    send_frame(0, 0);
    drain("case1");
    check_int("case1_count", seg_count, 4);
    check_int("case1_done", seg_done, 1);
    check_win("case1_first", seg_first, mkwin(0,1,2, 4,5,6, 8,9,10));
    check_win("case1_last", seg_last, mkwin(5,6,7, 9,10,11, 13,14,15));

    // 2: stall every other cycle
    seg_reset();
    send_frame(0, 1);
    drain("case2");
    check_int("case2_count", seg_count, 4);
    check_win("case2_first", seg_first, mkwin(0,1,2, 4,5,6, 8,9,10));
    check_win("case2_last", seg_last, mkwin(5,6,7, 9,10,11, 13,14,15));

    // 3: back-to-back frames
    seg_reset();
    send_frame(0, 0);
    send_frame(16, 0);
    drain("case3");
    check_int("case3_count", seg_count, 8);
    check_int("case3_done", seg_done, 2);
    check_win("case3_last", seg_last, mkwin(21,22,23, 25,26,27, 29,30,31));

    // 4: SOF mid-frame at pixel index 6
    seg_reset();
    for (int i = 0; i < 6; i++) drive(DW'(i), i == 0, 0);
    send_frame(100, 0);
    drain("case4");
    check_int("case4_count", seg_count, 4);
    check_int("case4_done", seg_done, 1);
    check_win("case4_first", seg_first, mkwin(100,101,102, 104,105,106, 108,109,110));

    // 5: async reset after pixel 9
    seg_reset();
    for (int i = 0; i < 10; i++) drive(DW'(i), i == 0, 0);
    #2;
    rst_n = 1'b0;
    m_active = 0;
    m_k = 0;
    exp_q.delete();
    done_exp = 0;
    #1;
    check_int("case5_rst_valid", int'(oValid), 0);
    check_win("case5_rst_window", got_win(), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < W*H; i++) drive(DW'(i), 1'b0, 0);
    drain("case5_nosof");
    check_int("case5_nosof_count", seg_count, 0);
    check_int("case5_nosof_done", seg_done, 0);
    seg_reset();
    send_frame(0, 0);
    drain("case5");
    check_int("case5_count", seg_count, 4);
    check_win("case5_first", seg_first, mkwin(0,1,2, 4,5,6, 8,9,10));
    check_win("case5_last", seg_last, mkwin(5,6,7, 9,10,11, 13,14,15));

    // 6: random pixels, random stalls, occasional aborted frames
    seg_reset();
    for (int f = 0; f < 40; f++) begin
      int len;
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, W*H-1)) : W*H;
      for (int i = 0; i < len; i++)
        drive(DW'($urandom), i == 0, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    drain("case6");

    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule
